// File: rtl/uart_tx_if.sv
// Byte-producer side of the UART transmitter: start strobe, data byte,
// and the serial line / busy flag coming back.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// tx and tx_busy come straight from flops, so nothing on the bus reaches the pin combinationally.
module uart_tx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic clk,
    input  logic reset,
    uart_tx_if.slave bus
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             tx_q,      tx_d;
    logic             busy_q,    busy_d;

    logic             cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    // The line value for the next bit period is computed one cycle early so
    // that tx itself can be a plain flop.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.tx_start) begin
                    shift_d = bus.tx_data;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                tx_d = 1'b0;
                if (cnt_last) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                tx_d = shift_q[bit_idx_q];
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the holding register is reset too; it is eight flops, not a
            // memory array, and a known value keeps a post-reset dump clean.
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at default baud settings: a line monitor
// decodes frames at bit centres and compares them against a scoreboard queue.
module tb_uart_tx;

    localparam int C = 50_000_000 / 115200;

    logic clk;
    logic reset;

    uart_tx_if u_if ();

    uart_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt = 0;
    int frames_seen = 0;
    logic [9:0] sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // frame[k] is the k-th bit on the wire
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (u_if.tx_busy === 1'b1) busy_cnt++;
    end

    // Line monitor: a falling edge starts a frame; reset mid-frame abandons it.
    initial begin : monitor
        logic       tx_prev;
        logic [9:0] got;
        logic [9:0] exp;
        logic       aborted;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && tx_prev === 1'b1 && u_if.tx === 1'b0) begin
                aborted = 1'b0;
                got     = '1;
                for (int c = 0; c < 10 * C; c++) begin
                    if (c > 0) @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % C == C / 2) got[c / C] = u_if.tx;
                end
                if (!aborted) begin
                    frames_seen++;
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_frame: got bits 0x%0h, expected no frame at %0t", got, $time);
                    end else begin
                        exp = sb_q.pop_front();
                        check("frame_bits", 32'(got), 32'(exp));
                    end
                end
            end
            tx_prev = u_if.tx;
        end
    end

    task automatic strobe(input logic [7:0] d);
        @(negedge clk);
        u_if.tx_start = 1'b1;
        u_if.tx_data  = d;
        @(negedge clk);
        u_if.tx_start = 1'b0;
        check("accept_busy", 32'(u_if.tx_busy), 32'd1);
        check("accept_tx",   32'(u_if.tx),      32'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (u_if.tx_busy !== 1'b0 && n < 12 * C) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(u_if.tx_busy === 1'b0), 32'd1);
    endtask

    initial begin : watchdog
        #(10 * 100_000);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[4];
        int   n;

        vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
        vecs[1] = '{8'h00, 10'b1_0000_0000_0};
        vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
        vecs[3] = '{8'h01, 10'b1_0000_0001_0};

        // Reset with tx_start held high: nothing may start.
        reset         = 1'b1;
        u_if.tx_start = 1'b1;
        u_if.tx_data  = 8'h5A;
        repeat (5) begin
            @(negedge clk);
            check("rst_tx",   32'(u_if.tx),      32'd1);
            check("rst_busy", 32'(u_if.tx_busy), 32'd0);
        end
        reset         = 1'b0;
        u_if.tx_start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(u_if.tx_busy), 32'd0);

        // Table-driven single frames.
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(vecs[i].frame);
            busy_cnt = 0;
            strobe(vecs[i].data);
            wait_idle();
            check("busy_len", 32'(busy_cnt), 32'(10 * C));
            repeat (C) @(negedge clk);
            check("idle_tx_after", 32'(u_if.tx), 32'd1);
        end

        // Strobe with 0xFF mid-frame of 0x00 is ignored.
        sb_q.push_back(10'b1_0000_0000_0);
        busy_cnt = 0;
        strobe(8'h00);
        repeat (3 * C) @(negedge clk);
        u_if.tx_start = 1'b1;
        u_if.tx_data  = 8'hFF;
        @(negedge clk);
        u_if.tx_start = 1'b0;
        wait_idle();
        check("ign_busy_len", 32'(busy_cnt), 32'(10 * C));
        repeat (2 * C) @(negedge clk);
        check("no_second_frame", 32'(u_if.tx_busy), 32'd0);

        // Back-to-back frames with tx_start held high.
        sb_q.push_back(10'b1_0101_0101_0);
        sb_q.push_back(10'b1_0000_1111_0);
        busy_cnt = 0;
        @(negedge clk);
        u_if.tx_start = 1'b1;
        u_if.tx_data  = 8'h55;
        @(negedge clk);
        u_if.tx_data  = 8'h0F;
        n = 0;
        while (u_if.tx_busy !== 1'b0 && n < 12 * C) begin
            @(negedge clk);
            n++;
        end
        check("b2b_gap_tx", 32'(u_if.tx), 32'd1);
        @(negedge clk);
        u_if.tx_start = 1'b0;
        check("b2b_restart_busy", 32'(u_if.tx_busy), 32'd1);
        check("b2b_restart_tx",   32'(u_if.tx),      32'd0);
        wait_idle();
        check("b2b_busy_len", 32'(busy_cnt), 32'(20 * C));

        // Reset during data bit 3 of 0xF0 (bit 3 is a zero on the line).
        strobe(8'hF0);
        repeat (4 * C + C / 2) @(negedge clk);
        check("pre_reset_bit3", 32'(u_if.tx), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx",   32'(u_if.tx),      32'd1);
        check("midrst_busy", 32'(u_if.tx_busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_midrst_tx", 32'(u_if.tx), 32'd1);
        sb_q.push_back(10'b1_0011_1100_0);
        busy_cnt = 0;
        strobe(8'h3C);
        wait_idle();
        check("after_rst_busy_len", 32'(busy_cnt), 32'(10 * C));

        // tx_data scrambled every cycle after accepting 0x81.
        sb_q.push_back(10'b1_1000_0001_0);
        busy_cnt = 0;
        @(negedge clk);
        u_if.tx_start = 1'b1;
        u_if.tx_data  = 8'h81;
        @(negedge clk);
        u_if.tx_start = 1'b0;
        n = 0;
        while (u_if.tx_busy !== 1'b0 && n < 12 * C) begin
            u_if.tx_data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        check("stab_busy_len", 32'(busy_cnt), 32'(10 * C));

        repeat (C) @(negedge clk);
        check("sb_empty",    32'(sb_q.size()), 32'd0);
        check("frames_seen", 32'(frames_seen), 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
